// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot loader: FSM encoding, byte-lane count and
// the lane-insert helper used by the byte packer.
package loader_pkg;

   localparam int BYTES_PER_WORD = 4;

   typedef enum logic [2:0] {
      S_LOAD    = 3'd0,
      S_WRITE   = 3'd1,
      S_RELEASE = 3'd2,
      S_RUN     = 3'd3,
      S_ERROR   = 3'd4
   } state_t;

   // Lane 0 occupies bits [7:0] (little-endian packing).
   function automatic logic [31:0] put_lane(input logic [31:0] w,
                                            input logic [1:0]  lane,
                                            input logic [7:0]  b);
      logic [31:0] r;
      r = w;
      r[8*lane +: 8] = b;
      return r;
   endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
interface program_loader_if;
   logic        ld_valid;
   logic [7:0]  ld_data;
   logic        ld_last;
   logic        ld_ready;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;

   modport master (
      output ld_valid, ld_data, ld_last,
      input  ld_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      input  ld_valid, ld_data, ld_last,
      output ld_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/program_loader_byte_packer.sv
// Packs accepted bytes into a 32-bit word; flags completion on lane 3 or on
// the final byte, and clears itself as the completed word is handed off.
module byte_packer
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        push_i,
   input  logic [7:0]  data_i,
   input  logic        last_i,
   output logic [31:0] word_o,
   output logic        word_done_o,
   output logic        last_o
);

   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [31:0] buf_q, buf_d;
   logic        full;

   always_comb begin
      word_o      = put_lane(buf_q, byte_cnt_q, data_i);
      full        = (byte_cnt_q == 2'(BYTES_PER_WORD - 1));
      word_done_o = push_i & (full | last_i);
      last_o      = push_i & last_i;
      byte_cnt_d  = byte_cnt_q;
      buf_d       = buf_q;
      // Upper lanes stay zero after a clear, so a short final word needs no masking.
      if (push_i) begin
         if (word_done_o) begin
            byte_cnt_d = '0;
            buf_d      = '0;
         end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            buf_d      = word_o;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         byte_cnt_q <= '0;
         buf_q      <= '0;
      end else begin
         byte_cnt_q <= byte_cnt_d;
         buf_q      <= buf_d;
      end
   end

endmodule

// File: rtl/program_loader.sv
// Boot sequencer: holds the core in reset, loads a byte stream into
// instruction memory, then releases the core after a hold interval.
module program_loader
   import loader_pkg::*;
#(
   parameter int          DEPTH       = 64,
   parameter logic [31:0] BASE_ADDR   = 32'h0,
   parameter int          HOLD_CYCLES = 4
)(
   input  logic             clk,
   input  logic             rst,
   program_loader_if.slave  ld_if,
   output logic             core_rst,
   output logic             done,
   output logic             err
);

   localparam int WCW = $clog2(DEPTH) + 1;
   localparam int HCW = $clog2(HOLD_CYCLES + 1);

   state_t          state_q, state_d;
   logic [WCW-1:0]  word_cnt_q, word_cnt_d;
   logic [HCW-1:0]  hold_q, hold_d;
   logic            last_flag_q, last_flag_d;
   logic            ready_q, ready_d;
   logic            we_q, we_d;
   logic [31:0]     addr_q, addr_d;
   logic [31:0]     wdata_q, wdata_d;
   logic            core_rst_q, core_rst_d;
   logic            done_q, done_d;
   logic            err_q, err_d;

   logic            accept;
   logic            image_full;
   logic            push;
   logic [31:0]     pk_word;
   logic            pk_done;
   logic            pk_last;

   assign accept     = ld_if.ld_valid & ready_q;
   assign image_full = (word_cnt_q == WCW'(DEPTH));
   assign push       = accept & (state_q == S_LOAD) & ~image_full;

   byte_packer u_packer (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push),
      .data_i      (ld_if.ld_data),
      .last_i      (ld_if.ld_last),
      .word_o      (pk_word),
      .word_done_o (pk_done),
      .last_o      (pk_last)
   );

   always_comb begin
      state_d     = state_q;
      word_cnt_d  = word_cnt_q;
      hold_d      = hold_q;
      last_flag_d = last_flag_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      unique case (state_q)
         S_LOAD: begin
            // A byte arriving after DEPTH words is consumed and dropped.
            if (accept && image_full) begin
               state_d = S_ERROR;
            end else if (pk_done) begin
               state_d     = S_WRITE;
               addr_d      = BASE_ADDR + (32'(word_cnt_q) << 2);
               wdata_d     = pk_word;
               last_flag_d = pk_last;
            end
         end
         S_WRITE: begin
            word_cnt_d = word_cnt_q + WCW'(1);
            hold_d     = '0;
            state_d    = last_flag_q ? S_RELEASE : S_LOAD;
         end
         S_RELEASE: begin
            if (hold_q == HCW'(HOLD_CYCLES - 1)) state_d = S_RUN;
            else                                 hold_d  = hold_q + HCW'(1);
         end
         S_RUN, S_ERROR: state_d = state_q;
         default:        state_d = S_LOAD;
      endcase
      // Outputs are registered from the next state so they align with state_q.
      ready_d    = (state_d == S_LOAD);
      we_d       = (state_d == S_WRITE);
      core_rst_d = (state_d != S_RUN);
      done_d     = (state_d == S_RUN);
      err_d      = (state_d == S_ERROR);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_LOAD;
         word_cnt_q  <= '0;
         hold_q      <= '0;
         last_flag_q <= 1'b0;
         ready_q     <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= BASE_ADDR;
         wdata_q     <= '0;
         core_rst_q  <= 1'b1;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         word_cnt_q  <= word_cnt_d;
         hold_q      <= hold_d;
         last_flag_q <= last_flag_d;
         ready_q     <= ready_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         core_rst_q  <= core_rst_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign ld_if.ld_ready   = ready_q;
   assign ld_if.imem_we    = we_q;
   assign ld_if.imem_addr  = addr_q;
   assign ld_if.imem_wdata = wdata_q;
   assign core_rst         = core_rst_q;
   assign done             = done_q;
   assign err              = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a transaction-level reference model
// checked every cycle, plus literal expectations for each scenario.
module tb_program_loader;

   localparam int          DEPTH = 4;
   localparam logic [31:0] BASE  = 32'h40;
   localparam int          HOLD  = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic core_rst, done, err;

   always #5 clk = ~clk;

   program_loader_if ifc ();

   program_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .HOLD_CYCLES(HOLD)) dut (
      .clk      (clk),
      .rst      (rst),
      .ld_if    (ifc),
      .core_rst (core_rst),
      .done     (done),
      .err      (err)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference model: phase 0 loading, 1 holding core in reset, 2 running, 3 error.
   bit          armed = 0;
   bit          e_ready, e_we, e_crst, e_done, e_err, e_rstc;
   logic [31:0] e_addr, e_data;
   int          m_lane, m_nwords, m_phase, m_rel;
   logic [31:0] m_word;
   bit          acc;
   logic        prev_crst = 1'b1;

   logic [31:0] wa[$];
   logic [31:0] wd[$];
   int          wc[$];
   int          fall_cyc = -1;

   always @(negedge clk) begin
      if (armed) begin
         chk("ld_ready", 32'(ifc.ld_ready), 32'(e_ready));
         chk("imem_we",  32'(ifc.imem_we),  32'(e_we));
         chk("core_rst", 32'(core_rst),     32'(e_crst));
         chk("done",     32'(done),         32'(e_done));
         chk("err",      32'(err),          32'(e_err));
         if (e_we) begin
            chk("imem_addr",  ifc.imem_addr,  e_addr);
            chk("imem_wdata", ifc.imem_wdata, e_data);
         end
         if (e_rstc) begin
            chk("rst_addr",  ifc.imem_addr,  BASE);
            chk("rst_wdata", ifc.imem_wdata, 32'h0);
         end
      end
      if (ifc.imem_we === 1'b1) begin
         wa.push_back(ifc.imem_addr);
         wd.push_back(ifc.imem_wdata);
         wc.push_back(cyc);
      end
      if (prev_crst === 1'b1 && core_rst === 1'b0) fall_cyc = cyc;
      prev_crst = core_rst;

      e_we   = 1'b0;
      e_rstc = 1'b0;
      if (rst) begin
         armed    = 1'b1;
         e_rstc   = 1'b1;
         e_ready  = 1'b0;
         e_crst   = 1'b1;
         e_done   = 1'b0;
         e_err    = 1'b0;
         m_lane   = 0;
         m_word   = '0;
         m_nwords = 0;
         m_phase  = 0;
      end else begin
         acc = (ifc.ld_valid === 1'b1) && e_ready;
         case (m_phase)
            0: if (acc) begin
               if (m_nwords == DEPTH) begin
                  m_phase = 3;
               end else begin
                  m_word[8*m_lane +: 8] = ifc.ld_data;
                  m_lane++;
                  if (m_lane == 4 || ifc.ld_last === 1'b1) begin
                     e_we   = 1'b1;
                     e_addr = BASE + 32'(4 * m_nwords);
                     e_data = m_word;
                     m_nwords++;
                     m_word = '0;
                     m_lane = 0;
                     if (ifc.ld_last === 1'b1) begin
                        m_phase = 1;
                        m_rel   = HOLD + 1;
                     end
                  end
               end
            end
            1: begin
               m_rel--;
               if (m_rel == 0) m_phase = 2;
            end
            default: ;
         endcase
         e_ready = (m_phase == 0) && !e_we;
         e_crst  = (m_phase != 2);
         e_done  = (m_phase == 2);
         e_err   = (m_phase == 3);
      end
   end

   task automatic send(input logic [7:0] d, input bit l);
      int n = 0;
      ifc.ld_valid = 1'b1;
      ifc.ld_data  = d;
      ifc.ld_last  = l;
      forever begin
         @(negedge clk);
         if (ifc.ld_ready === 1'b1) begin
            @(posedge clk); #1;
            break;
         end
         n++;
         if (n > 40) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: ld_ready=%b, required 1", ifc.ld_ready);
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic idle(input int n, input bit junk_valid);
      for (int i = 0; i < n; i++) begin
         ifc.ld_valid = junk_valid;
         ifc.ld_data  = 8'($urandom);
         ifc.ld_last  = 1'($urandom);
         @(posedge clk); #1;
      end
      ifc.ld_valid = 1'b0;
      ifc.ld_last  = 1'b0;
   endtask

   task automatic wait_end(input int max);
      int n = 0;
      ifc.ld_valid = 1'b0;
      ifc.ld_last  = 1'b0;
      while (!(done === 1'b1 || err === 1'b1)) begin
         @(negedge clk);
         n++;
         if (n > max) begin
            n_cmp++; n_bad++;
            $display("FAIL end_timeout: done=%b err=%b, required one set", done, err);
            break;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      ifc.ld_valid = 1'b0;
      ifc.ld_last  = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      wa.delete(); wd.delete(); wc.delete();
      fall_cyc = -1;
   endtask

   logic [7:0] t1[8]  = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00};
   logic [7:0] t5[10] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};

   initial begin
      ifc.ld_valid = 1'b0;
      ifc.ld_data  = 8'h0;
      ifc.ld_last  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("init_ready",    32'(ifc.ld_ready), 32'h0);
      chk("init_core_rst", 32'(core_rst),     32'h1);
      chk("init_addr",     ifc.imem_addr,     32'h40);
      do_reset();

      // Two full words, valid held high throughout.
      for (int i = 0; i < 8; i++) send(t1[i], i == 7);
      wait_end(60);
      chk("t1_nwr",   32'(wa.size()), 32'd2);
      if (wa.size() == 2) begin
         chk("t1_w0_data", wd[0], 32'h00500513);
         chk("t1_w0_addr", wa[0], 32'h40);
         chk("t1_w1_data", wd[1], 32'h00A00593);
         chk("t1_w1_addr", wa[1], 32'h44);
         chk("t1_gap",     32'(wc[1] - wc[0]), 32'd5);
         chk("t1_release", 32'(fall_cyc - wc[1]), 32'd4);
      end
      chk("t1_done", 32'(done), 32'h1);

      // Short final word.
      do_reset();
      send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0); send(8'hEF, 1);
      wait_end(60);
      idle(5, 1'b1);
      chk("t2_nwr", 32'(wa.size()), 32'd2);
      if (wa.size() == 2) begin
         chk("t2_w0_data", wd[0], 32'h04030201);
         chk("t2_w1_data", wd[1], 32'h000000EF);
         chk("t2_w1_addr", wa[1], 32'h44);
      end

      // Overflow past DEPTH words.
      do_reset();
      for (int i = 0; i < 16; i++) send(8'(i + 1), 0);
      send(8'hAA, 0);
      wait_end(60);
      idle(6, 1'b1);
      chk("t3_nwr",      32'(wa.size()), 32'd4);
      chk("t3_err",      32'(err),       32'h1);
      chk("t3_done",     32'(done),      32'h0);
      chk("t3_core_rst", 32'(core_rst),  32'h1);
      if (wa.size() == 4) begin
         chk("t3_w3_data", wd[3], 32'h100F0E0D);
         chk("t3_w3_addr", wa[3], 32'h4C);
      end

      // Exactly DEPTH words with last on the final byte.
      do_reset();
      for (int i = 0; i < 16; i++) send(8'(i + 1), i == 15);
      wait_end(60);
      chk("t3b_nwr",  32'(wa.size()), 32'd4);
      chk("t3b_done", 32'(done),      32'h1);
      chk("t3b_err",  32'(err),       32'h0);

      // Reset in the middle of the second word.
      do_reset();
      for (int i = 0; i < 6; i++) send(t1[i], 0);
      chk("t4_pre_nwr", 32'(wa.size()), 32'd1);
      do_reset();
      idle(3, 1'b0);
      chk("t4_post_nwr", 32'(wa.size()), 32'd0);
      send(8'h37, 0); send(8'h12, 0); send(8'h00, 0); send(8'h00, 1);
      wait_end(60);
      chk("t4_nwr", 32'(wa.size()), 32'd1);
      if (wa.size() == 1) begin
         chk("t4_w0_addr", wa[0], 32'h40);
         chk("t4_w0_data", wd[0], 32'h00001237);
      end

      // Gapped valid with junk while idle, and valid held through release/run.
      do_reset();
      for (int i = 0; i < 10; i++) begin
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3), 1'b0);
         send(t5[i], i == 9);
      end
      idle(12, 1'b1);
      chk("t5_nwr",  32'(wa.size()), 32'd3);
      chk("t5_done", 32'(done),      32'h1);
      if (wa.size() == 3) begin
         chk("t5_w0_data", wd[0], 32'h44332211);
         chk("t5_w1_data", wd[1], 32'h88776655);
         chk("t5_w2_data", wd[2], 32'h0000AA99);
      end

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
